// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// A byte moves on a rising edge when rx_valid and rx_ready are both high.
interface imem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte loader for the 256x32 instruction RAM.
// Holds the CPU in reset until a frame with a good checksum lands.
module imem_loader (
  input  logic              clk,
  input  logic              rstd,
  imem_loader_if.slave      rx,
  input  logic [31:0]       pc,
  output logic [31:0]       ins,
  output logic              cpu_rstd,
  output logic              busy,
  output logic              err,
  output logic [8:0]        words
);

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    DATA,
    CSUM,
    RUN
  } state_e;

  localparam logic [7:0] MAGIC = 8'hA5;

  state_e      state_q, state_d;
  logic [8:0]  tgt_q, tgt_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  xor_q, xor_d;
  logic        err_q, err_d;
  logic [8:0]  words_q, words_d;
  logic        cpu_q, cpu_d;

  logic [31:0] mem [256];
  logic        we;
  logic [31:0] wdata;
  logic        fire;
  logic        unused_pc;

  assign rx.rx_ready = rstd;
  assign fire        = rx.rx_valid & rx.rx_ready;
  assign unused_pc   = ^pc[31:8];

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    err_d   = err_q;
    words_d = words_q;
    cpu_d   = cpu_q;
    we      = 1'b0;
    wdata   = {asm_q[31:8], rx.rx_data};
    unique case (state_q)
      IDLE: begin
        if (fire && rx.rx_data == MAGIC) begin
          state_d = CNT;
          err_d   = 1'b0;
          words_d = '0;
          xor_d   = '0;
        end
      end
      CNT: begin
        if (fire) begin
          tgt_d   = (rx.rx_data == 8'd0) ? 9'd256
                                         : {1'b0, rx.rx_data};
          addr_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          xor_d = xor_q ^ rx.rx_data;
          // ~idx is 3-idx: big-endian byte lane
          asm_d[{~idx_q, 3'b000} +: 8] = rx.rx_data;
          if (idx_q == 2'd3) begin
            we      = 1'b1;
            addr_d  = addr_q + 8'd1;
            words_d = words_q + 9'd1;
            idx_d   = '0;
            if (words_q + 9'd1 == tgt_q)
              state_d = CSUM;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      CSUM: begin
        if (fire) begin
          if (rx.rx_data == xor_q) begin
            state_d = RUN;
            cpu_d   = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (fire && rx.rx_data == MAGIC) begin
          state_d = CNT;
          cpu_d   = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          xor_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
      cpu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      err_q   <= err_d;
      words_q <= words_d;
      cpu_q   <= cpu_d;
    end
  end

  // RAM survives rstd; contents persist across reloads
  always_ff @(posedge clk) begin
    if (we)
      mem[addr_q] <= wdata;
  end

  assign ins      = mem[pc[7:0]];
  assign cpu_rstd = cpu_q;
  assign err      = err_q;
  assign words    = words_q;
  assign busy     = (state_q == CNT) ||
                    (state_q == DATA) ||
                    (state_q == CSUM);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader.
// Frames are built from word lists; a shadow RAM predicts contents.
module tb_imem_loader;

  logic        clk;
  logic        rstd;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        cpu_rstd;
  logic        busy;
  logic        err;
  logic [8:0]  words;

  imem_loader_if rx ();

  imem_loader dut (
    .clk      (clk),
    .rstd     (rstd),
    .rx       (rx.slave),
    .pc       (pc),
    .ins      (ins),
    .cpu_rstd (cpu_rstd),
    .busy     (busy),
    .err      (err),
    .words    (words)
  );

  int n_chk;
  int n_err;

  logic [31:0] ref_mem [256];
  bit          ref_ok  [256];
  logic [31:0] pl      [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    rx.rx_valid = 1'b1;
    rx.rx_data  = b;
    @(posedge clk);
    #1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = $urandom;
  endtask

  task automatic check_mem();
    for (int a = 0; a < 256; a++) begin
      if (ref_ok[a]) begin
        pc = $urandom & 32'hFFFF_FF00 | a;
        #1;
        chk($sformatf("ram[%0d]", a), ins, ref_mem[a]);
      end
    end
  endtask

  task automatic run_frame(input int n, input bit bad, input int gmax);
    logic [7:0] fq [$];
    logic [7:0] cs;
    logic [7:0] cnt;
    int last;
    cs  = 8'h00;
    cnt = n[7:0];
    fq.push_back(8'hA5);
    fq.push_back(cnt);
    for (int w = 0; w < n; w++) begin
      for (int b = 3; b >= 0; b--) begin
        cs ^= pl[w][8*b +: 8];
        fq.push_back(pl[w][8*b +: 8]);
      end
    end
    fq.push_back(bad ? (cs ^ 8'h5A) : cs);
    last = fq.size() - 1;
    for (int i = 0; i <= last; i++) begin
      send_byte(fq[i], gmax);
      if (i == 0)
        chk("err_clr", {31'd0, err}, 32'd0);
      chk("cpu_rstd", {31'd0, cpu_rstd},
          {31'd0, (i == last) && !bad});
      chk("busy", {31'd0, busy}, {31'd0, i != last});
    end
    chk("err_end", {31'd0, err}, {31'd0, bad});
    chk("words", {23'd0, words}, n);
    for (int w = 0; w < n; w++) begin
      ref_mem[w] = pl[w];
      ref_ok[w]  = 1'b1;
    end
    check_mem();
  endtask

  initial begin
    int n;
    logic [31:0] w0;
    logic [31:0] w1;
    n_chk = 0;
    n_err = 0;
    for (int a = 0; a < 256; a++) ref_ok[a] = 1'b0;
    rstd        = 1'b0;
    pc          = '0;
    rx.rx_valid = 1'b0;
    rx.rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu", {31'd0, cpu_rstd}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words", {23'd0, words}, 32'd0);
    chk("rst_rdy", {31'd0, rx.rx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstd = 1'b1;
    #1;
    chk("rdy_up", {31'd0, rx.rx_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Two-word program, good then bad checksum
    pl[0] = 32'h0401_0001;
    pl[1] = 32'h0402_0001;
    run_frame(2, 1'b0, 0);
    pc = 32'd1;
    #1;
    chk("ins_pc1", ins, 32'h0402_0001);
    run_frame(2, 1'b1, 0);

    // Garbage before the magic byte is dropped
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h3C, 2);
    chk("garb_busy", {31'd0, busy}, 32'd0);
    chk("garb_err", {31'd0, err}, 32'd1);
    n = $urandom_range(16, 1);
    for (int w = 0; w < n; w++) pl[w] = $urandom;
    run_frame(n, 1'b0, 3);

    // Full 256-word image
    for (int w = 0; w < 256; w++) pl[w] = {4{w[7:0]}};
    run_frame(256, 1'b0, 0);

    // Reload from RUN, then abort with rstd mid-payload
    send_byte(8'hA5, 0);
    chk("rerun_cpu", {31'd0, cpu_rstd}, 32'd0);
    chk("rerun_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h04, 1);
    w0 = $urandom;
    w1 = $urandom;
    for (int b = 3; b >= 0; b--) send_byte(w0[8*b +: 8], 1);
    send_byte(w1[31:24], 1);
    send_byte(w1[23:16], 1);
    chk("part_words", {23'd0, words}, 32'd1);
    ref_mem[0] = w0;
    rstd = 1'b0;
    #2;
    chk("abort_cpu", {31'd0, cpu_rstd}, 32'd0);
    chk("abort_words", {23'd0, words}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdy", {31'd0, rx.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rstd = 1'b1;
    check_mem();

    // Random frames, random checksum faults and gaps
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(24, 1);
      for (int w = 0; w < n; w++) pl[w] = $urandom;
      run_frame(n, bit'($urandom_range(1, 0)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
